ddr3_port_arbiter: RTL and testbench

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

---
 rtl/ddr3_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter that hands one DDR3 bridge port to one of NUM_REQ requesters.
// Optional idle-owner forced release is enabled by defining DDR3_ARB_TIMEOUT_EN.
module ddr3_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*28-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_rd,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*8-1:0]  req_din,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [27:0]           ddr3_addr,
    output logic                  ddr3_rd,
    output logic                  ddr3_wr,
    output logic [7:0]            ddr3_din,
    output logic                  ddr3_request,
    input  logic                  ddr3_ready,
    output logic                  timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_s;
    logic [PTR_W-1:0]   ptr_r, ptr_s;
    logic               ddr3_request_r, ddr3_request_s;
    logic               timeout_s;
    logic               force_rel_s;

    logic [NUM_REQ-1:0] avail_s;
    logic [NUM_REQ-1:0] win_oh_s;
    logic               win_found_s;
    logic [PTR_W-1:0]   win_ptr_s;

    logic               owner_req_s, owner_rd_s, owner_wr_s;
    logic [27:0]        owner_addr_s;
    logic [7:0]         owner_din_s;

    // Round-robin pick: scan from the pointer to the top, then wrap to the bottom.
    always_comb begin
        win_oh_s    = '0;
        win_found_s = 1'b0;
        win_ptr_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && (i >= int'(ptr_r)) && avail_s[i]) begin
                win_found_s = 1'b1;
                win_oh_s[i] = 1'b1;
                win_ptr_s   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && (i < int'(ptr_r)) && avail_s[i]) begin
                win_found_s = 1'b1;
                win_oh_s[i] = 1'b1;
                win_ptr_s   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // AND-OR select of the owner's request, strobes and data via the one-hot grant.
    always_comb begin
        owner_req_s  = 1'b0;
        owner_rd_s   = 1'b0;
        owner_wr_s   = 1'b0;
        owner_addr_s = 28'd0;
        owner_din_s  = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_req_s  = owner_req_s | (req[i] & gnt_r[i]);
            owner_rd_s   = owner_rd_s | (req_rd[i] & gnt_r[i]);
            owner_wr_s   = owner_wr_s | (req_wr[i] & gnt_r[i]);
            owner_addr_s = owner_addr_s | (req_addr[28*i +: 28] & {28{gnt_r[i]}});
            owner_din_s  = owner_din_s | (req_din[8*i +: 8] & {8{gnt_r[i]}});
        end
    end

    // Next-state, next-grant and round-robin pointer update.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        ptr_s     = ptr_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    gnt_s   = win_oh_s;
                    ptr_s   = win_ptr_s;
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    if (ddr3_ready) begin
                        gnt_s   = '0;
                        state_s = ST_RELEASE;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (force_rel_s) begin
                    gnt_s     = '0;
                    timeout_s = 1'b1;
                    state_s   = ST_RELEASE;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                if (ddr3_ready) begin
                    gnt_s   = '0;
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_RELEASE: begin
                gnt_s   = '0;
                state_s = ST_IDLE;
            end
            default: begin
                gnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
        ddr3_request_s = (state_s == ST_GRANT) || (state_s == ST_DRAIN);
    end

    // Arbiter state registers; reset abandons any access without draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            gnt_r          <= '0;
            ptr_r          <= '0;
            ddr3_request_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            gnt_r          <= gnt_s;
            ptr_r          <= ptr_s;
            ddr3_request_r <= ddr3_request_s;
        end
    end

`ifdef DDR3_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] mask_r;
    logic               timeout_r;
    logic               owner_idle_s;

    assign owner_idle_s = ~owner_rd_s & ~owner_wr_s & ddr3_ready;
    assign force_rel_s  = (state_r == ST_GRANT) && owner_idle_s &&
                          (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign avail_s      = req & ~mask_r;
    assign timeout      = timeout_r;

    // Idle-owner counter, timed-out owner mask and timeout pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= '0;
            mask_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            if ((state_r != ST_GRANT) || !owner_idle_s) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_W'(TIMEOUT_CYCLES - 1)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // A masked requester is only released once it lowers its request.
            mask_r    <= (mask_r & req) | (timeout_s ? gnt_r : '0);
            timeout_r <= timeout_s;
        end
    end
`else
    logic unused_timeout_s;

    assign force_rel_s      = 1'b0;
    assign avail_s          = req;
    assign timeout          = 1'b0;
    assign unused_timeout_s = timeout_s ^ (TIMEOUT_CYCLES == 0);
`endif

    assign gnt          = gnt_r;
    assign req_ready    = gnt_r & {NUM_REQ{ddr3_ready}};
    assign ddr3_request = ddr3_request_r;
    assign ddr3_rd      = (state_r == ST_GRANT) & owner_rd_s;
    assign ddr3_wr      = (state_r == ST_GRANT) & owner_wr_s;
    assign ddr3_addr    = owner_addr_s;
    assign ddr3_din     = owner_din_s;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed self-checking bench for ddr3_port_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_ddr3_port_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req, req_rd, req_wr;
    logic [N*28-1:0] req_addr;
    logic [N*8-1:0] req_din;
    logic [N-1:0]   gnt, req_ready;
    logic [27:0]    ddr3_addr;
    logic           ddr3_rd, ddr3_wr, ddr3_request, ddr3_ready, timeout;
    logic [7:0]     ddr3_din;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .req_rd(req_rd), .req_wr(req_wr), .req_din(req_din), .gnt(gnt),
        .req_ready(req_ready), .ddr3_addr(ddr3_addr), .ddr3_rd(ddr3_rd),
        .ddr3_wr(ddr3_wr), .ddr3_din(ddr3_din), .ddr3_request(ddr3_request),
        .ddr3_ready(ddr3_ready), .timeout(timeout)
    );

    function automatic logic [27:0] addr_of(int i);
        return 28'hA00_0000 + 28'(i) * 28'h0011;
    endfunction

    function automatic logic [7:0] din_of(int i);
        return 8'h30 + 8'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; req_wr = '0; ddr3_ready = 1'b1;
        req_rd = 4'b1111;
        repeat (2) step();
        n_cmp++;
        if ({gnt, req_ready, ddr3_request, ddr3_rd, ddr3_wr, timeout} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got gnt=%b rdy=%b rq=%b rd=%b wr=%b to=%b want all 0",
                     gnt, req_ready, ddr3_request, ddr3_rd, ddr3_wr, timeout);
        end
        n_cmp++;
        if (ddr3_addr !== 28'd0 || ddr3_din !== 8'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h din=%h want 0/0", ddr3_addr, ddr3_din);
        end
        req_rd = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single_grant();
        req = 4'b0001; ddr3_ready = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 4'b0001 || ddr3_request !== 1'b1 || req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL single_gnt: got gnt=%b rq=%b rdy=%b want 0001/1/0001", gnt, ddr3_request, req_ready);
        end
        req_rd = 4'b0001; req_wr = 4'b0100;
        #1;
        n_cmp++;
        if (ddr3_rd !== 1'b1 || ddr3_wr !== 1'b0 || ddr3_addr !== addr_of(0) || ddr3_din !== din_of(0)) begin
            n_err++;
            $display("FAIL single_fwd: got rd=%b wr=%b addr=%h din=%h want 1/0/%h/%h",
                     ddr3_rd, ddr3_wr, ddr3_addr, ddr3_din, addr_of(0), din_of(0));
        end
        req_rd = '0; req_wr = '0; req = '0;
        step();
        n_cmp++;
        if (gnt !== 4'b0000 || ddr3_request !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: got gnt=%b rq=%b want 0000/0", gnt, ddr3_request);
        end
        step();
    endtask

    task automatic test_round_robin();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        req = 4'b1111; ddr3_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] want;
            want = 4'b0001 << exp_idx[k];
            step();
            n_cmp++;
            if (gnt !== want) begin
                n_err++;
                $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, want);
            end
            req_wr = want;
            req[exp_idx[k]] = 1'b0;
            #1;
            n_cmp++;
            if (ddr3_wr !== 1'b1 || ddr3_addr !== addr_of(exp_idx[k])) begin
                n_err++;
                $display("FAIL rr_fwd%0d: got wr=%b addr=%h want 1/%h", k, ddr3_wr, ddr3_addr, addr_of(exp_idx[k]));
            end
            step();
            req_wr = '0;
            req[exp_idx[k]] = 1'b1;
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL rr_gap1_%0d: got %b want 0000", k, gnt);
            end
            step();
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL rr_gap2_%0d: got %b want 0000", k, gnt);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_drain();
        req = 4'b0100; ddr3_ready = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL drain_gnt: got %b want 0100", gnt);
        end
        ddr3_ready = 1'b0; req_rd = 4'b0100;
        #1;
        n_cmp++;
        if (ddr3_rd !== 1'b1) begin
            n_err++;
            $display("FAIL busy_fwd: got rd=%b want 1", ddr3_rd);
        end
        req_rd = '0; req = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0100 || ddr3_request !== 1'b1 || req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL drain_hold%0d: got gnt=%b rq=%b rdy=%b want 0100/1/0000", k, gnt, ddr3_request, req_ready);
            end
            req_rd = 4'b0100;
            #1;
            n_cmp++;
            if (ddr3_rd !== 1'b0) begin
                n_err++;
                $display("FAIL drain_block%0d: got rd=%b want 0", k, ddr3_rd);
            end
            req_rd = '0;
        end
        ddr3_ready = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 4'b0000 || ddr3_request !== 1'b0) begin
            n_err++;
            $display("FAIL drain_release: got gnt=%b rq=%b want 0000/0", gnt, ddr3_request);
        end
        step();
    endtask

    task automatic test_async_reset();
        req = 4'b0010; ddr3_ready = 1'b1;
        step();
        req_rd = 4'b0010;
        #1;
        n_cmp++;
        if (gnt !== 4'b0010 || ddr3_rd !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre: got gnt=%b rd=%b want 0010/1", gnt, ddr3_rd);
        end
        req = 4'b1111;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, req_ready, ddr3_request, ddr3_rd, ddr3_wr} !== 11'd0 || ddr3_addr !== 28'd0 || ddr3_din !== 8'd0) begin
            n_err++;
            $display("FAIL arst_out: got gnt=%b rdy=%b rq=%b rd=%b addr=%h din=%h want all 0",
                     gnt, req_ready, ddr3_request, ddr3_rd, ddr3_addr, ddr3_din);
        end
        req_rd = '0;
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL arst_next: got %b want 0001", gnt);
        end
        req = '0;
        repeat (2) step();
    endtask

    task automatic test_timeout();
        req = 4'b0010; ddr3_ready = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL to_gnt: got %b want 0010", gnt);
        end
`ifdef DDR3_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL to_hold%0d: got gnt=%b to=%b want 0010/0", k, gnt, timeout);
            end
        end
        step();
        n_cmp++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL to_pulse: got gnt=%b to=%b want 0000/1", gnt, timeout);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0000 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL to_masked%0d: got gnt=%b to=%b want 0000/0", k, gnt, timeout);
            end
        end
        req = '0;
        step();
        req = 4'b0010;
        step();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL to_regrant: got %b want 0010", gnt);
        end
`else
        for (int k = 0; k < 40; k++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL to_held%0d: got gnt=%b to=%b want 0010/0", k, gnt, timeout);
            end
        end
`endif
        req = '0;
        repeat (2) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[28*i +: 28] = addr_of(i);
            req_din[8*i +: 8]    = din_of(i);
        end
        test_reset();
        test_single_grant();
        test_round_robin();
        test_drain();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
